// File: rtl/spmv_hbm_rd_engine.sv
// HBM read DMA: splits (base, beat-count) commands into 4 KB-safe AXI4 INCR read bursts with
// bounded outstanding bursts, and returns the read data in order as an AXI-Stream.
module spmv_hbm_rd_engine #(
  parameter int ADDR_W          = 48,
  parameter int DATA_W          = 256,
  parameter int MAX_BURST_LEN   = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              axis_clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_beats,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                arvalid_q, arvalid_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [7:0]          arlen_q, arlen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         rem_q, rem_d;
  logic [31:0]         beats_q, beats_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                rready_q, rready_d;
  logic                tvalid_q, tvalid_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic                tlast_q, tlast_d;
  logic                skid_v_q, skid_v_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic [31:0]         ld_cnt_q, ld_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                accept_s, ar_hs_s, r_hs_s, t_hs_s, last_hs_s;
  logic [8:0]          len_cmd_s, len_nxt_s;
  logic [ADDR_W-1:0]   cmd_base_s;
  logic                unused_s;

  // Beats in the next burst: bounded by what is left, the burst cap and the 4 KB page end.
  function automatic logic [8:0] burst_len(input logic [6:0] off, input logic [31:0] rem);
    logic [31:0] bnd;
    logic [31:0] l;
    bnd = 32'd128 - {25'd0, off};
    l   = (rem > 32'(MAX_BURST_LEN)) ? 32'(MAX_BURST_LEN) : rem;
    l   = (l > bnd) ? bnd : l;
    return 9'(l);
  endfunction

  assign cmd_base_s = {cmd_addr[ADDR_W-1:5], 5'b0_0000};
  assign unused_s   = ^cmd_addr[4:0];
  assign accept_s   = cmd_valid & cmd_ready_q;
  assign ar_hs_s    = arvalid_q & m_axi_arready;
  assign r_hs_s     = m_axi_rvalid & rready_q;
  assign t_hs_s     = tvalid_q & m_axis_tready;
  assign last_hs_s  = t_hs_s & tlast_q;
  assign len_cmd_s  = burst_len(cmd_addr[11:5], cmd_beats);
  assign len_nxt_s  = burst_len(addr_q[11:5], rem_q);

  // State register.
  always_ff @(posedge axis_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (accept_s && cmd_beats != 32'd0) ? ISSUE : IDLE;
      ISSUE:   state_d = (ar_hs_s && rem_q == 32'd0) ? DRAIN : ISSUE;
      DRAIN:   state_d = last_hs_s ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    arvalid_d   = arvalid_q & ~m_axi_arready;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    beats_d     = beats_q;
    ld_cnt_d    = ld_cnt_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;
    skid_v_d    = skid_v_q;
    skid_d      = skid_q;

    case ({ar_hs_s, r_hs_s & m_axi_rlast})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // rem/addr always describe what is left after the burst currently on AR.
    if (accept_s && cmd_beats != 32'd0) begin
      arvalid_d = 1'b1;
      araddr_d  = cmd_base_s;
      arlen_d   = 8'(len_cmd_s - 9'd1);
      addr_d    = cmd_base_s + {{(ADDR_W-14){1'b0}}, len_cmd_s, 5'b0_0000};
      rem_d     = cmd_beats - {23'd0, len_cmd_s};
    end else if (state_q == ISSUE && (!arvalid_q || m_axi_arready) && rem_q != 32'd0 &&
                 cnt_d < CW'(MAX_OUTSTANDING)) begin
      arvalid_d = 1'b1;
      araddr_d  = addr_q;
      arlen_d   = 8'(len_nxt_s - 9'd1);
      addr_d    = addr_q + {{(ADDR_W-14){1'b0}}, len_nxt_s, 5'b0_0000};
      rem_d     = rem_q - {23'd0, len_nxt_s};
    end else begin
      rem_d = rem_q;
    end

    if (accept_s) begin
      beats_d  = cmd_beats;
      ld_cnt_d = 32'd0;
    end else begin
      beats_d = beats_q;
    end

    // Output register is the head of a 2-entry buffer; the skid entry only fills while stalled.
    if (!tvalid_q || t_hs_s) begin
      if (skid_v_q) begin
        tvalid_d = 1'b1;
        tdata_d  = skid_q;
        tlast_d  = (ld_cnt_q == beats_q - 32'd1);
        ld_cnt_d = ld_cnt_q + 32'd1;
        skid_v_d = r_hs_s;
        skid_d   = m_axi_rdata;
      end else if (r_hs_s) begin
        tvalid_d = 1'b1;
        tdata_d  = m_axi_rdata;
        tlast_d  = (ld_cnt_q == beats_q - 32'd1);
        ld_cnt_d = ld_cnt_q + 32'd1;
      end else begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    end else if (r_hs_s) begin
      skid_v_d = 1'b1;
      skid_d   = m_axi_rdata;
    end else begin
      skid_v_d = skid_v_q;
    end
    rready_d = ~(tvalid_d & skid_v_d);

    if (accept_s) begin
      busy_d = (cmd_beats != 32'd0);
    end else if (last_hs_s) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    done_d = last_hs_s | (accept_s & (cmd_beats == 32'd0));

    if (accept_s) begin
      err_d = 1'b0;
    end else if (r_hs_s && m_axi_rresp != 2'b00) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge axis_clk or posedge rst) begin
    if (rst) begin
      cmd_ready_q <= 1'b0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= 8'd0;
      addr_q      <= '0;
      rem_q       <= 32'd0;
      beats_q     <= 32'd0;
      cnt_q       <= '0;
      rready_q    <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      skid_v_q    <= 1'b0;
      skid_q      <= '0;
      ld_cnt_q    <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      beats_q     <= beats_d;
      cnt_q       <= cnt_d;
      rready_q    <= rready_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      skid_v_q    <= skid_v_d;
      skid_q      <= skid_d;
      ld_cnt_q    <= ld_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'b101;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule
